// File: rtl/mem_sequencer_pkg.sv
// Shared definitions for the instruction/data memory sequencer:
// default bus widths, instruction opcodes and FSM state encoding.
package mem_sequencer_pkg;

    localparam int AW_DEF = 13;
    localparam int DW_DEF = 8;

    typedef enum logic [2:0] {
        HLT = 3'b000,
        SKZ = 3'b001,
        ADD = 3'b010,
        AND = 3'b011,
        XOR = 3'b100,
        LDA = 3'b101,
        STO = 3'b110,
        JMP = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        F_HI  = 3'd1,
        F_LO  = 3'd2,
        D_RD  = 3'd3,
        W_SET = 3'd4,
        W_STB = 3'd5,
        W_HLD = 3'd6,
        DONE  = 3'd7
    } state_t;

endpackage

// File: rtl/mem_sequencer.sv
// Sequences 2-byte instruction fetches, data reads and setup/strobe/hold
// data writes onto a single shared RAM/ROM bus.
module mem_sequencer
    import mem_sequencer_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [AW-1:0] pc,
    input  logic          dacc_req,
    input  logic          dacc_we,
    input  logic [AW-1:0] dacc_addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [15:0]   ir,
    output logic [2:0]    opcode,
    output logic [AW-1:0] operand,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    inout  wire  [DW-1:0] mem_data
);

    state_t        state, state_nxt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          drive_bus;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: next state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fetch_req)     state_nxt = F_HI;
                else if (dacc_req) state_nxt = dacc_we ? W_SET : D_RD;
            end
            F_HI:    state_nxt = F_LO;
            F_LO:    state_nxt = DONE;
            D_RD:    state_nxt = DONE;
            W_SET:   state_nxt = W_STB;
            W_STB:   state_nxt = W_HLD;
            W_HLD:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address and write data are captured at acceptance so requester-side
    // changes cannot disturb a transaction already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            ir      <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        addr_q <= pc;
                    end else if (dacc_req) begin
                        addr_q  <= dacc_addr;
                        wdata_q <= wdata;
                    end
                end
                F_HI:    ir[15:8] <= 8'(mem_data);
                F_LO:    ir[7:0]  <= 8'(mem_data);
                D_RD:    rdata    <= mem_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_addr = '0;
        case (state)
            F_HI, D_RD, W_SET, W_STB, W_HLD: mem_addr = addr_q;
            F_LO:                            mem_addr = addr_q + AW'(1);
            default:                         ;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign mem_read  = (state == F_HI) || (state == F_LO) || (state == D_RD);
    assign mem_write = (state == W_STB);
    assign drive_bus = (state == W_SET) || (state == W_STB) || (state == W_HLD);
    assign mem_data  = drive_bus ? wdata_q : 'z;

    assign opcode  = ir[2:0];
    assign operand = AW'(ir[15:3]);

endmodule

// File: tb/tb_mem_sequencer.sv
// Randomized scoreboard bench for mem_sequencer: a behavioural RAM on the
// shared bus, a reference model feeding expectations, and a done-driven monitor.
module tb_mem_sequencer;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int MSZ = 1 << AW;
    localparam int K_FETCH = 0;
    localparam int K_READ  = 1;
    localparam int K_WRITE = 2;

    typedef struct {
        int          kind;
        int          exp_cyc;
        logic [15:0] ir;
        logic [7:0]  rd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req, dacc_req, dacc_we;
    logic [AW-1:0] pc, dacc_addr;
    logic [DW-1:0] wdata;
    logic          busy, done, mem_read, mem_write;
    logic [15:0]   ir;
    logic [2:0]    opcode;
    logic [AW-1:0] operand, mem_addr;
    logic [DW-1:0] rdata;
    wire  [DW-1:0] mem_data;

    logic [7:0]  mem     [MSZ];
    logic [7:0]  ref_mem [MSZ];
    logic [15:0] last_ir;
    logic [7:0]  last_rd;
    exp_t        sb[$];
    int          cyc = 0;
    int          wr_edges = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  park_val;
    logic        park_en;

    mem_sequencer #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc(pc),
        .dacc_req(dacc_req), .dacc_we(dacc_we), .dacc_addr(dacc_addr),
        .wdata(wdata), .busy(busy), .done(done), .ir(ir), .opcode(opcode),
        .operand(operand), .rdata(rdata), .mem_addr(mem_addr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_data(mem_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge mem_write) wr_edges <= wr_edges + 1;

    // The RAM answers reads combinationally; when the sequencer should have
    // released the bus in IDLE, a changing pattern is parked on it instead.
    assign park_val = 8'(cyc ^ 32'h3C);
    assign park_en  = !busy && !mem_read;
    assign mem_data = mem_read ? mem[mem_addr] : (park_en ? park_val : 8'bz);

    initial forever begin
        @(posedge clk);
        if (mem_write) mem[mem_addr] = mem_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat(input int kind);
        return (kind == K_FETCH) ? 2 : (kind == K_READ) ? 1 : 3;
    endfunction

    function automatic void model_issue(input int kind, input logic [AW-1:0] a,
                                        input logic [7:0] wd, input int exp_cyc);
        exp_t e;
        case (kind)
            K_FETCH: last_ir = {ref_mem[a], ref_mem[(int'(a) + 1) % MSZ]};
            K_READ:  last_rd = ref_mem[a];
            default: ref_mem[a] = wd;
        endcase
        e.kind = kind; e.exp_cyc = exp_cyc; e.ir = last_ir; e.rd = last_rd;
        sb.push_back(e);
    endfunction

    // Monitor: pops an expectation on every done pulse.
    initial begin
        exp_t e;
        int   wr_seen;
        wr_seen = 0;
        forever begin
            @(negedge clk);
            check("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
            if (!busy) check("idle_bus_released", {24'b0, mem_data}, {24'b0, park_val});
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.exp_cyc));
                    check("ir", {16'b0, ir}, {16'b0, e.ir});
                    check("rdata", {24'b0, rdata}, {24'b0, e.rd});
                    check("write_strobes", 32'(wr_edges - wr_seen), 32'(e.kind == K_WRITE));
                    if (e.kind == K_FETCH) begin
                        check("opcode", {29'b0, opcode}, {29'b0, e.ir[2:0]});
                        check("operand", {19'b0, operand}, {19'b0, e.ir[15:3]});
                    end
                end
                wr_seen = wr_edges;
            end else if (sb.size() > 0 && cyc > sb[0].exp_cyc) begin
                check("done_cycle", 32'(cyc), 32'(sb[0].exp_cyc));
                void'(sb.pop_front());
            end
        end
    end

    task automatic run_txn(input int kind, input logic [AW-1:0] a, input logic [7:0] wd);
        @(negedge clk);
        fetch_req = (kind == K_FETCH);
        dacc_req  = (kind != K_FETCH);
        dacc_we   = (kind == K_WRITE);
        pc = a; dacc_addr = a; wdata = wd;
        model_issue(kind, a, wd, cyc + 1 + lat(kind));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pc = AW'($urandom); dacc_addr = AW'($urandom); wdata = 8'($urandom);
            if (done) break;
        end
        fetch_req = 1'b0;
        dacc_req  = 1'b0;
    endtask

    task automatic run_both(input logic [AW-1:0] fa, input logic [AW-1:0] ra);
        int ndone;
        @(negedge clk);
        fetch_req = 1'b1; pc = fa;
        dacc_req = 1'b1; dacc_we = 1'b0; dacc_addr = ra;
        model_issue(K_FETCH, fa, 8'h00, cyc + 3);
        model_issue(K_READ, ra, 8'h00, cyc + 6);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) fetch_req = 1'b0;
                else break;
            end
        end
        fetch_req = 1'b0;
        dacc_req  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_mem_read"}, {31'b0, mem_read}, 32'd0);
        check({tag, "_mem_write"}, {31'b0, mem_write}, 32'd0);
        check({tag, "_mem_addr"}, {19'b0, mem_addr}, 32'd0);
        check({tag, "_ir"}, {16'b0, ir}, 32'd0);
        check({tag, "_rdata"}, {24'b0, rdata}, 32'd0);
        check({tag, "_bus_released"}, {24'b0, mem_data}, {24'b0, park_val});
    endtask

    task automatic reset_mid_write(input logic [AW-1:0] a);
        int w0;
        w0 = wr_edges;
        @(negedge clk);
        dacc_req = 1'b1; dacc_we = 1'b1; dacc_addr = a; wdata = ~ref_mem[a];
        @(negedge clk);
        #2;
        rst = 1'b1;
        dacc_req = 1'b0;
        #1;
        check_reset_outputs("midrst");
        last_ir = '0;
        last_rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_no_strobe", 32'(wr_edges - w0), 32'd0);
        check("midrst_mem_intact", {24'b0, mem[a]}, {24'b0, ref_mem[a]});
        rst = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        int            kind;
        rst = 1'b1;
        fetch_req = 1'b0; dacc_req = 1'b0; dacc_we = 1'b0;
        pc = '0; dacc_addr = '0; wdata = '0;
        last_ir = '0; last_rd = '0;
        for (int i = 0; i < MSZ; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[2] = 8'h09; ref_mem[2] = 8'h09;
        mem[3] = 8'h66; ref_mem[3] = 8'h66;
        mem[MSZ-1] = 8'hAA; ref_mem[MSZ-1] = 8'hAA;
        mem[0] = 8'h00; ref_mem[0] = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        run_txn(K_FETCH, 13'd2, 8'h00);
        check("fetch2_ir", {16'b0, ir}, 32'h0966);
        check("fetch2_opcode", {29'b0, opcode}, 32'b110);
        check("fetch2_operand", {19'b0, operand}, 32'd300);

        run_txn(K_WRITE, 13'd300, 8'h05);
        run_txn(K_READ, 13'd300, 8'h00);
        check("rd300_rdata", {24'b0, rdata}, 32'h05);

        run_txn(K_FETCH, 13'h1FFF, 8'h00);
        check("wrap_ir", {16'b0, ir}, 32'hAA00);

        run_both(13'd2, 13'd300);
        reset_mid_write(13'd300);
        run_txn(K_READ, 13'd300, 8'h00);
        check("after_rst_rdata", {24'b0, rdata}, 32'h05);

        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 2));
            a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(290, 309)) : AW'($urandom);
            if ($urandom_range(0, 9) == 0) run_both(a, AW'($urandom_range(290, 309)));
            else run_txn(kind, a, 8'($urandom));
        end

        repeat (6) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 The block SHALL have parameter AW, default 13, meaning the memory address width.
REQ-002 The block SHALL have parameter DW, default 8, meaning the memory data width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port fetch_req  input  1  level request to fetch a 2-byte instruction at pc.
REQ-006 The block SHALL have port pc  input  AW  instruction address, high byte first.
REQ-007 The block SHALL have port dacc_req  input  1  level request for a data access.
REQ-008 The block SHALL have port dacc_we  input  1  1 = data write, 0 = data read.
REQ-009 The block SHALL have port dacc_addr  input  AW  data access address.
REQ-010 The block SHALL have port wdata  input  DW  write data.
REQ-011 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse on transaction completion.
REQ-013 The block SHALL have port ir  output  16  fetched instruction {hi,lo}.
REQ-014 The block SHALL have port opcode  output  3  ir[2:0].
REQ-015 The block SHALL have port operand  output  AW  ir[15:3].
REQ-016 The block SHALL have port rdata  output  DW  captured read data.
REQ-017 The block SHALL have ports mem_addr output AW, mem_read output 1, mem_write output 1, mem_data inout DW, driving the 13-bit/8-bit RAM/ROM with combinational read and posedge-write strobe.

Function
REQ-018 The FSM SHALL have states IDLE, F_HI, F_LO, D_RD, W_SET, W_STB, W_HLD, DONE.
REQ-019 Requests SHALL be sampled only in IDLE; fetch_req has priority over dacc_req when both are high; the loser is ignored and must be held by the requester.
REQ-020 Fetch: F_HI drives mem_addr=pc, mem_read=1, captures ir[15:8] at the edge; F_LO drives mem_addr=(pc+1) mod 2^AW, mem_read=1, captures ir[7:0]; then DONE.
REQ-021 Fetch latency SHALL be: request accepted at edge E0, done=1 during the cycle after edge E2, with ir stable from E2.
REQ-022 Data read: D_RD drives mem_addr=dacc_addr, mem_read=1, captures rdata at the edge, then DONE (done 2 cycles after acceptance).
REQ-023 Data write SHALL use W_SET (addr/data driven, mem_write=0), then W_STB (mem_write=1), then W_HLD (mem_write=0, addr/data still driven), then DONE, giving exactly one rising edge of mem_write with one cycle of setup and one cycle of hold.
REQ-024 dacc_addr, pc and wdata SHALL be registered at acceptance; later input changes SHALL NOT affect an in-flight transaction.
REQ-025 mem_data SHALL be driven only in W_SET/W_STB/W_HLD and be high-Z otherwise; mem_read and mem_write SHALL never be high together.
REQ-026 DONE SHALL last one cycle and return to IDLE; a request still high in IDLE SHALL start a new transaction.
REQ-027 ir and rdata SHALL hold their values until overwritten by the next fetch or read respectively.

Reset
REQ-028 rst SHALL immediately force IDLE, busy=0, done=0, mem_read=0, mem_write=0, mem_addr=0, ir=0, rdata=0, and mem_data high-Z, including mid-transaction; a write interrupted after the W_STB edge is not rolled back.

Structure
REQ-029 A shared package SHALL hold the opcode constants HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111, the state encoding, and AW/DW defaults.
REQ-030 The block SHALL be a single FSM module with no sub-module.

Verification
REQ-031 With mem[2]=0x09 and mem[3]=0x66, fetch at pc=2 -> ir=0x0966, opcode=110, operand=300, with done 3 cycles after acceptance.
REQ-032 Writing 0x05 to address 300 and then reading address 300 -> exactly one mem_write rising edge, rdata=0x05, and mem_data high-Z outside the write states.
REQ-033 With mem[0x1FFF]=0xAA and mem[0]=0x00, fetch at pc=0x1FFF -> the second read addresses 0x0000 and ir=0xAA00.
REQ-034 fetch_req and dacc_req raised in the same cycle -> fetch is performed first; the held dacc_req is served next, starting in the IDLE cycle after DONE.
REQ-035 rst asserted during W_SET -> mem_write never rises, memory is unchanged, and all outputs reach their reset values without waiting for a clock edge.
